// File: rtl/cache_line_addr_gen_if.sv
// Handshake and multiplier bundle for the cache line address generator.
// "master" is the generator side, "slave" is its environment.
interface cache_line_addr_gen_if #(
   parameter int CNT_W = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [15:0]      req_idx;
   logic [CNT_W-1:0] req_cnt;
   logic [15:0]      mul_in;
   logic [19:0]      mul_out;
   logic             addr_valid;
   logic             addr_ready;
   logic [19:0]      addr;
   logic             addr_last;
   logic             done;

   modport master (
      input  req_valid, req_idx, req_cnt, mul_out, addr_ready,
      output req_ready, mul_in, addr_valid, addr, addr_last, done
   );

   modport slave (
      output req_valid, req_idx, req_cnt, mul_out, addr_ready,
      input  req_ready, mul_in, addr_valid, addr, addr_last, done
   );
endinterface

// File: rtl/cache_line_addr_gen.sv
// Line-burst word address generator: idx*10+k for each line of a request,
// using an external registered x10 stage for the line base address.
module cache_line_addr_gen #(
   parameter int WPL   = 10,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   cache_line_addr_gen_if.master bus
);
   localparam logic [3:0] K_LAST = 4'(WPL - 1);

   typedef enum logic [1:0] {IDLE, LOAD, BASE, BURST} state_t;

   state_t           state, state_nxt;
   logic [15:0]      idx_r;
   logic [CNT_W-1:0] left_r;
   logic [19:0]      base_r;
   logic [3:0]       k_r;
   logic             done_r;
   logic             accept;
   logic             hs;
   logic             line_end;
   logic             last_line;

   assign line_end   = (k_r == K_LAST);
   assign last_line  = (left_r == CNT_W'(1));
   assign bus.mul_in = idx_r;
   assign bus.done   = done_r;

   always_comb begin
      state_nxt      = state;
      accept         = 1'b0;
      hs             = 1'b0;
      bus.req_ready  = 1'b0;
      bus.addr_valid = 1'b0;
      bus.addr       = '0;
      bus.addr_last  = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            accept        = bus.req_valid;
            if (accept && (bus.req_cnt != '0))
               state_nxt = LOAD;
         end
         LOAD: state_nxt = BASE;
         BASE: state_nxt = BURST;
         BURST: begin
            bus.addr_valid = 1'b1;
            bus.addr       = base_r + 20'(k_r);
            bus.addr_last  = line_end && last_line;
            hs             = bus.addr_ready;
            if (hs && line_end)
               state_nxt = last_line ? IDLE : LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx_r  <= '0;
         left_r <= '0;
         base_r <= '0;
         k_r    <= '0;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= 1'b0;
         if (accept) begin
            idx_r  <= bus.req_idx;
            left_r <= bus.req_cnt;
            done_r <= (bus.req_cnt == '0);
         end
         // mul_out holds 10*idx_r captured at the end of LOAD
         if (state == BASE) begin
            base_r <= bus.mul_out;
            k_r    <= '0;
         end
         if (hs) begin
            if (line_end) begin
               left_r <= left_r - 1'b1;
               idx_r  <= idx_r + 1'b1;
               done_r <= last_line;
            end else begin
               k_r <= k_r + 1'b1;
            end
         end
      end
   end
endmodule
